// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ valid/ready/last streams onto a
// single FIFO write port through a 1-entry output register tagged with the ID.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = $clog2(MAX_BURST) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fifo_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
  input  logic                           fifo_full,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy
);

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  logic                           state;
  logic [ID_WIDTH-1:0]            rr_ptr;
  logic [CNT_WIDTH-1:0]           beat_cnt;
  logic                           out_valid;
  logic [ID_WIDTH+DATA_WIDTH-1:0] out_data;

  logic [ID_WIDTH-1:0]            cand;
  logic [ID_WIDTH-1:0]            winner;
  logic                           any_valid;
  logic [DATA_WIDTH-1:0]          sel_data;
  logic                           sel_valid;
  logic                           sel_last;
  logic                           slot_free;
  logic                           xfer;
  logic                           burst_end;
  logic [ID_WIDTH-1:0]            next_ptr;

  // Rotating scan starting at rr_ptr; modulo keeps it correct for non-power-of-2 NUM_REQ.
  always_comb begin
    cand      = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_WIDTH'((32'(rr_ptr) + i) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  assign slot_free = !out_valid || !fifo_full;
  assign xfer      = (state == STATE_LOCKED) && sel_valid && slot_free;
  assign burst_end = xfer && (sel_last || (beat_cnt == CNT_WIDTH'(MAX_BURST - 1)));
  assign next_ptr  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == STATE_LOCKED) && slot_free && (grant_id == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STATE_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            beat_cnt <= '0;
            state    <= STATE_LOCKED;
          end
        end
        STATE_LOCKED: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          if (burst_end) begin
            state  <= STATE_IDLE;
            rr_ptr <= next_ptr;
          end
        end
      endcase
    end
  end

  // A load while draining keeps out_valid high, giving one beat per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= {grant_id, sel_data};
    end else if (fifo_wr_en) begin
      out_valid <= 1'b0;
    end
  end

  assign fifo_wr_en = out_valid && !fifo_full;
  assign fifo_din   = out_data;
  assign busy       = (state == STATE_LOCKED) || out_valid;

endmodule
